// File: rtl/sequence_engine_pkg.sv
// Shared types and constants for the memory-sequence game engine.
package sequence_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_SHOW_ON,
        ST_SHOW_OFF,
        ST_WAIT_IN,
        ST_OVER
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sequence_engine_if.sv
// Player/host-facing signals of the sequence engine.
interface sequence_engine_if #(
    parameter int NUM_TILES = 4,
    parameter int MAX_LEN   = 16
);
    localparam int TW = $clog2(NUM_TILES);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic          start;
    logic          mode;
    logic          press_valid;
    logic [TW-1:0] press_tile;
    logic          show_valid;
    logic [TW-1:0] show_tile;
    logic          await_input;
    logic [LW-1:0] score;
    logic [LW-1:0] best;
    logic          game_over;
    logic          win;

    modport master (
        output start, mode, press_valid, press_tile,
        input  show_valid, show_tile, await_input, score, best, game_over, win
    );

    modport slave (
        input  start, mode, press_valid, press_tile,
        output show_valid, show_tile, await_input, score, best, game_over, win
    );

endinterface

// File: rtl/sequence_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; the low bits pick the next tile.
module sequence_lfsr
    import sequence_engine_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED,
    parameter int          TW   = 2
)
(
    input  logic          clk,
    input  logic          rst,
    output logic [TW-1:0] tile
);

    logic [15:0] lfsr;

    // Advance on every clock regardless of game state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= SEED;
        else     lfsr <= lfsr_next(lfsr);
    end

    assign tile = lfsr[TW-1:0];

endmodule

// File: rtl/sequence_engine.sv
// Memory-sequence game: plays back a random tile sequence and checks the
// player's echo, growing (mode 0) or reshuffling (mode 1) each round.
//
// state       | meaning
// ST_IDLE     | after reset, waiting for start
// ST_FILL     | writing new tile(s) into the sequence memory
// ST_SHOW_ON  | tile mem[idx] lit for ON_CYCLES
// ST_SHOW_OFF | blank gap of OFF_CYCLES after each tile
// ST_WAIT_IN  | collecting player presses, timeout armed
// ST_OVER     | game ended (win or loss), waiting for start
module sequence_engine
    import sequence_engine_pkg::*;
#(
    parameter int          NUM_TILES      = 4,
    parameter int          MAX_LEN        = 16,
    parameter int          ON_CYCLES      = 25000000,
    parameter int          OFF_CYCLES     = 12500000,
    parameter int          TIMEOUT_CYCLES = 150000000,
    parameter logic [15:0] SEED           = DEFAULT_SEED
)
(
    input logic              clk,
    input logic              rst,
    sequence_engine_if.slave bus
);

    localparam int TW      = $clog2(NUM_TILES);
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMR_A   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMR_MAX = (TMR_A > TIMEOUT_CYCLES) ? TMR_A : TIMEOUT_CYCLES;
    localparam int TMRW    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    // Timers count down to zero; each load value is the phase length minus one.
    localparam logic [TMRW-1:0] ON_LOAD  = TMRW'(ON_CYCLES - 1);
    localparam logic [TMRW-1:0] OFF_LOAD = TMRW'(OFF_CYCLES - 1);
    localparam logic [TMRW-1:0] TO_LOAD  = TMRW'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic            mode_r;
    logic [LW-1:0]   len;
    logic [LW-1:0]   idx;
    logic [TMRW-1:0] timer;
    logic [LW-1:0]   score_r;
    logic [LW-1:0]   best_r;
    logic            show_valid_r;
    logic            await_r;
    logic            game_over_r;
    logic            win_r;

    logic [TW-1:0]   mem [MAX_LEN];
    logic [TW-1:0]   new_tile;
    logic            mem_we;
    logic [IW-1:0]   mem_waddr;
    logic            idx_last;
    logic            fill_done;
    logic            press_hit;

    sequence_lfsr #(.SEED(SEED), .TW(TW)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .tile (new_tile)
    );

    assign idx_last  = (idx == len - LW'(1));
    assign fill_done = (idx == len);
    assign press_hit = (bus.press_tile == mem[idx[IW-1:0]]);

    // Grow mode appends at len; reshuffle mode rewrites entry idx each FILL cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        if (state == ST_FILL) begin
            mem_we    = 1'b1;
            mem_waddr = mode_r ? idx[IW-1:0] : len[IW-1:0];
        end
    end

    // Sequence storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= new_tile;
    end

    // Game FSM with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            mode_r       <= 1'b0;
            len          <= '0;
            idx          <= '0;
            timer        <= '0;
            score_r      <= '0;
            best_r       <= '0;
            show_valid_r <= 1'b0;
            await_r      <= 1'b0;
            game_over_r  <= 1'b0;
            win_r        <= 1'b0;
        end else begin
            game_over_r <= 1'b0;
            win_r       <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (bus.start) begin
                        mode_r  <= bus.mode;
                        len     <= '0;
                        idx     <= '0;
                        score_r <= '0;
                        state   <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (!mode_r || fill_done) begin
                        len          <= len + 1'b1;
                        idx          <= '0;
                        timer        <= ON_LOAD;
                        show_valid_r <= 1'b1;
                        state        <= ST_SHOW_ON;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_SHOW_ON: begin
                    if (timer == '0) begin
                        timer        <= OFF_LOAD;
                        show_valid_r <= 1'b0;
                        state        <= ST_SHOW_OFF;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_SHOW_OFF: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (!idx_last) begin
                        idx          <= idx + 1'b1;
                        timer        <= ON_LOAD;
                        show_valid_r <= 1'b1;
                        state        <= ST_SHOW_ON;
                    end else begin
                        idx     <= '0;
                        timer   <= TO_LOAD;
                        await_r <= 1'b1;
                        state   <= ST_WAIT_IN;
                    end
                end
                ST_WAIT_IN: begin
                    // A press in the final timeout cycle still counts.
                    if (bus.press_valid && press_hit && !idx_last) begin
                        idx   <= idx + 1'b1;
                        timer <= TO_LOAD;
                    end else if (bus.press_valid && press_hit) begin
                        score_r <= len;
                        if (len > best_r) best_r <= len;
                        idx     <= '0;
                        await_r <= 1'b0;
                        if (len == LW'(MAX_LEN)) begin
                            win_r <= 1'b1;
                            state <= ST_OVER;
                        end else begin
                            state <= ST_FILL;
                        end
                    end else if (bus.press_valid || timer == '0) begin
                        game_over_r <= 1'b1;
                        await_r     <= 1'b0;
                        state       <= ST_OVER;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.show_valid  = show_valid_r;
    assign bus.show_tile   = show_valid_r ? mem[idx[IW-1:0]] : '0;
    assign bus.await_input = await_r;
    assign bus.score       = score_r;
    assign bus.best        = best_r;
    assign bus.game_over   = game_over_r;
    assign bus.win         = win_r;

endmodule

// File: tb/tb_sequence_engine.sv
// Directed bench for sequence_engine with a small tile-sequence model.
module tb_sequence_engine;

    localparam int          NT   = 4;
    localparam int          ML   = 4;
    localparam int          ON   = 4;
    localparam int          OFF  = 2;
    localparam int          TO   = 20;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_lfsr;
    logic [1:0]  m_mem [ML];
    int          m_len;

    sequence_engine_if #(.NUM_TILES(NT), .MAX_LEN(ML)) bus ();

    sequence_engine #(
        .NUM_TILES      (NT),
        .MAX_LEN        (ML),
        .ON_CYCLES      (ON),
        .OFF_CYCLES     (OFF),
        .TIMEOUT_CYCLES (TO),
        .SEED           (SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    // One clock; afterwards m_lfsr mirrors the DUT LFSR for the new cycle.
    task automatic tick();
        @(posedge clk);
        if (!rst) m_lfsr = model_step(m_lfsr);
        #1;
    endtask

    task automatic do_start(input logic md);
        bus.start       = 1'b1;
        bus.mode        = md;
        bus.press_valid = 1'b1;
        bus.press_tile  = 2'd3;
        tick();
        bus.start       = 1'b0;
        bus.press_valid = 1'b0;
        m_len = 0;
        check("start_score_clear", bus.score, 0);
        check("fill_dark", bus.show_valid, 0);
    endtask

    // Entered in the first FILL cycle; returns in the first WAIT_IN cycle.
    task automatic fill_and_show(input logic md, input bit inject);
        if (md == 1'b0) begin
            m_mem[m_len] = m_lfsr[1:0];
            tick();
        end else begin
            for (int i = 0; i <= m_len; i++) begin
                check("fill_len", bus.show_valid, 0);
                m_mem[i] = m_lfsr[1:0];
                tick();
            end
        end
        m_len++;
        for (int i = 0; i < m_len; i++) begin
            for (int c = 0; c < ON; c++) begin
                check("show_on", {bus.show_valid, bus.show_tile}, {1'b1, m_mem[i]});
                if (c == 0) check("await_lo_show", bus.await_input, 0);
                if (inject) begin
                    bus.press_valid = 1'b1;
                    bus.press_tile  = m_mem[i] ^ 2'd1;
                end
                tick();
            end
            bus.press_valid = 1'b0;
            for (int c = 0; c < OFF; c++) begin
                check("show_off", {bus.show_valid, bus.show_tile}, 0);
                tick();
            end
        end
        check("await_hi", bus.await_input, 1);
    endtask

    task automatic echo(input int wrong_at);
        for (int i = 0; i < m_len; i++) begin
            bus.press_valid = 1'b1;
            bus.press_tile  = (i == wrong_at) ? (m_mem[i] ^ 2'd1) : m_mem[i];
            tick();
            bus.press_valid = 1'b0;
            if (i == wrong_at) begin
                check("wrong_gameover", bus.game_over, 1);
                check("wrong_await_drop", bus.await_input, 0);
                return;
            end
            if (i < m_len - 1) begin
                check("mid_await", bus.await_input, 1);
                check("mid_no_gameover", bus.game_over, 0);
            end else begin
                check("round_score", bus.score, m_len);
                check("round_await_drop", bus.await_input, 0);
                check("round_win", bus.win, (m_len == ML));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = 1'b0;
        bus.mode        = 1'b0;
        bus.press_valid = 1'b0;
        bus.press_tile  = 2'd0;
        m_lfsr          = SEED;
        m_len           = 0;
        for (int i = 0; i < ML; i++) m_mem[i] = 2'd0;

        // Reset state
        tick();
        tick();
        check("rst_show_valid", bus.show_valid, 0);
        check("rst_show_tile", bus.show_tile, 0);
        check("rst_await", bus.await_input, 0);
        check("rst_score", bus.score, 0);
        check("rst_best", bus.best, 0);
        check("rst_game_over", bus.game_over, 0);
        check("rst_win", bus.win, 0);
        rst = 1'b0;
        tick();
        tick();

        // Game A: grow mode, echo all four rounds to a win
        do_start(1'b0);
        for (int r = 1; r <= ML; r++) begin
            fill_and_show(1'b0, 1'b0);
            echo(-1);
            check("a_best", bus.best, r);
        end
        tick();
        check("a_win_single", bus.win, 0);
        check("a_score_hold", bus.score, 4);
        for (int k = 0; k < 3; k++) begin
            bus.press_valid = 1'b1;
            bus.press_tile  = 2'd2;
            tick();
            check("a_over_dark", bus.show_valid, 0);
            check("a_over_no_gameover", bus.game_over, 0);
            check("a_over_await", bus.await_input, 0);
        end
        bus.press_valid = 1'b0;

        // Game B: wrong tile on second press of round 3
        do_start(1'b0);
        check("b_best_kept", bus.best, 4);
        fill_and_show(1'b0, 1'b0);
        echo(-1);
        fill_and_show(1'b0, 1'b0);
        echo(-1);
        fill_and_show(1'b0, 1'b0);
        echo(1);
        check("b_score", bus.score, 2);
        check("b_best", bus.best, 4);
        tick();
        check("b_gameover_one_cycle", bus.game_over, 0);

        // Game C: timeout, then last-cycle presses accepted
        do_start(1'b0);
        fill_and_show(1'b0, 1'b0);
        for (int k = 0; k < TO; k++) begin
            check("c_wait_await", bus.await_input, 1);
            check("c_wait_no_gameover", bus.game_over, 0);
            tick();
        end
        check("c_timeout_gameover", bus.game_over, 1);
        check("c_timeout_await", bus.await_input, 0);
        check("c_timeout_score", bus.score, 0);
        tick();
        check("c_timeout_one_cycle", bus.game_over, 0);

        do_start(1'b0);
        fill_and_show(1'b0, 1'b0);
        for (int k = 0; k < TO - 1; k++) tick();
        bus.press_valid = 1'b1;
        bus.press_tile  = m_mem[0];
        tick();
        bus.press_valid = 1'b0;
        check("c_late_no_gameover", bus.game_over, 0);
        check("c_late_score", bus.score, 1);
        fill_and_show(1'b0, 1'b0);
        for (int k = 0; k < TO - 1; k++) tick();
        bus.press_valid = 1'b1;
        bus.press_tile  = m_mem[0];
        tick();
        bus.press_valid = 1'b0;
        check("c_timer_restart_await", bus.await_input, 1);
        check("c_timer_restart_no_go", bus.game_over, 0);
        for (int k = 0; k < TO - 1; k++) tick();
        bus.press_valid = 1'b1;
        bus.press_tile  = m_mem[1];
        tick();
        bus.press_valid = 1'b0;
        check("c_late2_no_gameover", bus.game_over, 0);
        check("c_late2_score", bus.score, 2);

        // Reset asserted mid-playback (round 3 tile 0 lit)
        m_mem[2] = m_lfsr[1:0];
        tick();
        check("d_pre_show", bus.show_valid, 1);
        tick();
        #3;
        rst    = 1'b1;
        m_lfsr = SEED;
        #1;
        check("d_rst_show_valid", bus.show_valid, 0);
        check("d_rst_show_tile", bus.show_tile, 0);
        check("d_rst_score", bus.score, 0);
        check("d_rst_best", bus.best, 0);
        check("d_rst_await", bus.await_input, 0);
        tick();
        rst = 1'b0;
        tick();
        check("d_idle_dark", bus.show_valid, 0);

        // Game E: reshuffle mode, presses during playback ignored
        do_start(1'b1);
        check("e_best_after_rst", bus.best, 0);
        for (int r = 1; r <= 3; r++) begin
            fill_and_show(1'b1, 1'b1);
            echo(-1);
            check("e_best", bus.best, r);
        end
        fill_and_show(1'b1, 1'b1);
        echo(0);
        check("e_score", bus.score, 3);
        check("e_best_final", bus.best, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
